// File: rtl/cpu_read_mux_pkg.sv
// -----------------------------------------------------------------------------
// cpu_read_mux_pkg
// Shared definitions for the Z80 read-data multiplexer:
//   - read-cycle FSM state encodings (ST_IDLE / ST_WAIT / ST_HOLD)
//   - source-select width and the SEL_BUS code meaning "S-100 bus data-in"
//   - default source index assignments on the CPU data-in selector
// -----------------------------------------------------------------------------
package cpu_read_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Select code width; codes 0..14 name a source, 15 names the bus.
    // This limits NUM_SRC to at most 15.
    localparam int              SEL_W   = 4;
    localparam logic [SEL_W-1:0] SEL_BUS = 4'hF;

    localparam int COLL_W = 8;

    // Default source indices, highest priority first.
    localparam int SRC_ROM      = 0;
    localparam int SRC_RESETJAM = 1;
    localparam int SRC_IDE      = 2;
    localparam int SRC_PORTCON  = 3;
    localparam int SRC_RAM      = 4;
    localparam int SRC_LED      = 5;
    localparam int SRC_IOBYTE   = 6;
    localparam int SRC_USBRXD   = 7;
    localparam int SRC_USBSTAT  = 8;

endpackage

// File: rtl/cpu_read_mux_if.sv
// -----------------------------------------------------------------------------
// cpu_read_mux_if
// Bundles the device data-out buses, CPU strobes and the CPU-facing results.
//   src_data   : flat source data, source i at [i*DATA_W +: DATA_W]
//   src_cs     : per-source selects, active high
//   bus_data   : S-100 bus data-in, used when no select is active
//   force_zero : reset-vector jam, overrides everything
//   z80_read   : CPU read strobe, active high
//   coll_clr   : clears collision flag and counter
//   out_data / data_valid / cpu_wait / coll_flag / coll_count : registered results
// master = driver of the inputs (CPU side / bench), slave = the multiplexer.
// -----------------------------------------------------------------------------
interface cpu_read_mux_if #(
    parameter int NUM_SRC = 10,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_cs;
    logic [DATA_W-1:0]         bus_data;
    logic                      force_zero;
    logic                      z80_read;
    logic                      coll_clr;
    logic [DATA_W-1:0]         out_data;
    logic                      data_valid;
    logic                      cpu_wait;
    logic                      coll_flag;
    logic [7:0]                coll_count;

    modport master (
        output src_data, src_cs, bus_data, force_zero, z80_read, coll_clr,
        input  out_data, data_valid, cpu_wait, coll_flag, coll_count
    );

    modport slave (
        input  src_data, src_cs, bus_data, force_zero, z80_read, coll_clr,
        output out_data, data_valid, cpu_wait, coll_flag, coll_count
    );
endinterface

// File: rtl/cpu_read_mux_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Combinational lowest-index priority encoder.
//   i_req   : request vector, bit 0 has the highest priority
//   o_idx   : index of the lowest set bit (0 when none set)
//   o_any   : at least one request set
//   o_multi : two or more requests set
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_multi
);

    always_comb begin
        o_idx   = '0;
        o_any   = 1'b0;
        o_multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i]) begin
                // First hit fixes the index; any later hit marks a collision.
                if (o_any) begin
                    o_multi = 1'b1;
                end else begin
                    o_idx = IDX_W'(i);
                end
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_read_mux.sv
// -----------------------------------------------------------------------------
// cpu_read_mux
// Registered read-data multiplexer for the Z80 data-in port. At each read
// start (rising edge of z80_read) it picks the lowest-index active select (or
// the S-100 bus when none), waits that source's programmed number of cycles
// with cpu_wait asserted, captures the byte once and holds it with data_valid
// until the strobe drops. Chip-select collisions at read start are flagged
// and counted (saturating).
// Ports:
//   pll0_250MHz : clock
//   n_reset     : synchronous active-low reset
//   bus         : cpu_read_mux_if.slave (sources, strobes, registered outputs)
// -----------------------------------------------------------------------------
module cpu_read_mux
    import cpu_read_mux_pkg::*;
#(
    parameter int                        NUM_SRC  = 10,
    parameter int                        DATA_W   = 8,
    parameter int                        WAIT_W   = 4,
    parameter logic [NUM_SRC*WAIT_W-1:0] WAIT_CYC = '0
) (
    input logic           pll0_250MHz,
    input logic           n_reset,
    cpu_read_mux_if.slave bus
);

    state_t              r_state;
    state_t              w_nxt_state;
    logic                r_read_d;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_idx;
    logic [SEL_W-1:0]    w_sel;
    logic [SEL_W-1:0]    w_cap_sel;
    logic                w_any;
    logic                w_multi;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WAIT_W-1:0]   w_wait_n;
    logic                w_read_start;
    logic                w_load;
    logic                w_capture;
    logic                w_coll;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_wait;
    logic                r_coll_flag;
    logic [COLL_W-1:0]   r_coll_count;

    function automatic logic [WAIT_W-1:0] wait_of(input logic [SEL_W-1:0] s);
        logic [WAIT_W-1:0] n;
        n = '0;  // the bus code has no wait states
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s == SEL_W'(i)) n = WAIT_CYC[i*WAIT_W +: WAIT_W];
        end
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] data_of(
        input logic [SEL_W-1:0]          s,
        input logic [NUM_SRC*DATA_W-1:0] srcs,
        input logic [DATA_W-1:0]         bus_d
    );
        logic [DATA_W-1:0] d;
        d = bus_d;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s == SEL_W'(i)) d = srcs[i*DATA_W +: DATA_W];
        end
        return d;
    endfunction

    function automatic logic [COLL_W-1:0] sat_inc(input logic [COLL_W-1:0] v);
        return (v == {COLL_W{1'b1}}) ? v : v + COLL_W'(1);
    endfunction

    // One encoder serves both source selection and collision detection.
    prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (SEL_W)
    ) u_prio_enc (
        .i_req   (bus.src_cs),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    assign w_sel        = w_any ? w_idx : SEL_BUS;
    assign w_wait_n     = wait_of(w_sel);
    assign w_read_start = bus.z80_read & ~r_read_d;
    assign w_coll       = w_load & w_multi;

    always_ff @(posedge pll0_250MHz) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // force_zero wins over everything, including a read start in IDLE.
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_cap_sel   = r_sel;
        if (bus.force_zero) begin
            w_nxt_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_read_start) begin
                        w_load = 1'b1;
                        if (w_wait_n != '0) begin
                            w_nxt_state = ST_WAIT;
                        end else begin
                            // Zero-wait source: capture at the read-start edge.
                            w_capture   = 1'b1;
                            w_cap_sel   = w_sel;
                            w_nxt_state = ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.z80_read) begin
                        w_nxt_state = ST_IDLE;  // abort, nothing captured
                    end else if (r_cnt == WAIT_W'(1)) begin
                        w_capture   = 1'b1;
                        w_nxt_state = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!bus.z80_read) w_nxt_state = ST_IDLE;
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    // Register stage: selection/count, captured byte, status and collisions.
    // cpu_wait and data_valid are derived from the next state so they line up
    // with the state register.
    always_ff @(posedge pll0_250MHz) begin
        if (!n_reset) begin
            r_read_d     <= 1'b0;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_wait       <= 1'b0;
            r_coll_flag  <= 1'b0;
            r_coll_count <= '0;
        end else begin
            r_read_d <= bus.z80_read;
            r_wait   <= (w_nxt_state == ST_WAIT);
            r_valid  <= (w_nxt_state == ST_HOLD);

            if (w_load) begin
                r_sel <= w_sel;
                r_cnt <= w_wait_n;
            end else if (r_state == ST_WAIT && w_nxt_state == ST_WAIT) begin
                r_cnt <= r_cnt - WAIT_W'(1);
            end

            if (bus.force_zero) begin
                r_data <= '0;
            end else if (w_capture) begin
                r_data <= data_of(w_cap_sel, bus.src_data, bus.bus_data);
            end

            // A collision in the clearing cycle still registers as the first.
            if (bus.coll_clr) begin
                r_coll_flag  <= w_coll;
                r_coll_count <= w_coll ? COLL_W'(1) : '0;
            end else if (w_coll) begin
                r_coll_flag  <= 1'b1;
                r_coll_count <= sat_inc(r_coll_count);
            end
        end
    end

    assign bus.out_data   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.cpu_wait   = r_wait;
    assign bus.coll_flag  = r_coll_flag;
    assign bus.coll_count = r_coll_count;

endmodule
